// File: rtl/param_micro_proc_if.sv
// Bus bundle for param_micro_proc: run control, program load port,
// keyboard handshake and architectural status.
interface param_micro_proc_if #(
    parameter int DW = 4,
    parameter int AW = 3
);
    logic          run;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW+3:0] prog_data;
    logic [DW-1:0] kbd_data;
    logic          kbd_valid;
    logic          kbd_ready;
    logic [DW-1:0] DataOut;
    logic          out_valid;
    logic [DW-1:0] acc;
    logic          carry;
    logic          zero;
    logic [AW-1:0] pc;
    logic          halted;

    modport master (
        output run, prog_we, prog_addr, prog_data, kbd_data, kbd_valid,
        input  kbd_ready, DataOut, out_valid, acc, carry, zero, pc, halted
    );

    modport slave (
        input  run, prog_we, prog_addr, prog_data, kbd_data, kbd_valid,
        output kbd_ready, DataOut, out_valid, acc, carry, zero, pc, halted
    );
endinterface

// File: rtl/param_micro_proc.sv
// Tiny accumulator machine: immediate-operand ISA, loadable program memory,
// keyboard input handshake and a single output register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for run; program memory writable
// FETCH   | IR <= mem[pc], pc advances (wraps)
// DECODE  | one dead cycle, nothing architectural changes
// EXEC    | execute opcode held in IR
// WAIT_IN | kbd_ready high, waiting for kbd_valid to load acc
// HALT    | everything held; memory writable; run=0 returns to IDLE
module param_micro_proc #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input logic           clk1,
    input logic           MainClear,
    param_micro_proc_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXEC    = 3'd3,
        WAIT_IN = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'h3;
    localparam logic [3:0] OP_IN  = 4'h4;
    localparam logic [3:0] OP_LDA = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t        state, state_nxt;
    logic [DW+3:0] mem [2**AW];
    logic [DW+3:0] ir_q, ir_nxt;
    logic [AW-1:0] pc_q, pc_nxt;
    logic [DW-1:0] acc_q, acc_nxt;
    logic [DW-1:0] dout_q, dout_nxt;
    logic          carry_q, carry_nxt;
    logic          zero_q, zero_nxt;
    logic          outv_q, outv_nxt;
    logic          kbdr_q, halt_q;
    logic          zupd;

    logic [3:0]    opcode;
    logic [DW-1:0] operand;
    logic [DW:0]   sum, diff;

    assign opcode  = ir_q[DW+3:DW];
    assign operand = ir_q[DW-1:0];
    assign sum     = {1'b0, acc_q} + {1'b0, operand};
    // The extra MSB of the difference is the borrow out.
    assign diff    = {1'b0, acc_q} - {1'b0, operand};

    always_ff @(posedge clk1 or negedge MainClear) begin
        if (!MainClear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
        acc_nxt   = acc_q;
        carry_nxt = carry_q;
        zero_nxt  = zero_q;
        dout_nxt  = dout_q;
        outv_nxt  = 1'b0;
        zupd      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    pc_nxt    = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                ir_nxt    = mem[pc_q];
                pc_nxt    = pc_q + 1'b1;
                state_nxt = DECODE;
            end
            DECODE: state_nxt = EXEC;
            EXEC: begin
                state_nxt = FETCH;
                case (opcode)
                    OP_ADD: begin {carry_nxt, acc_nxt} = sum;  zupd = 1'b1; end
                    OP_SUB: begin {carry_nxt, acc_nxt} = diff; zupd = 1'b1; end
                    OP_OUT: begin dout_nxt = acc_q; outv_nxt = 1'b1; end
                    OP_IN:  state_nxt = WAIT_IN;
                    OP_LDA: begin acc_nxt = operand;         zupd = 1'b1; end
                    OP_AND: begin acc_nxt = acc_q & operand; zupd = 1'b1; end
                    OP_OR:  begin acc_nxt = acc_q | operand; zupd = 1'b1; end
                    OP_JMP: pc_nxt = operand[AW-1:0];
                    OP_JZ:  if (zero_q) pc_nxt = operand[AW-1:0];
                    OP_HLT: state_nxt = HALT;
                    default: ;
                endcase
            end
            WAIT_IN: begin
                if (bus.kbd_valid) begin
                    acc_nxt   = bus.kbd_data;
                    zupd      = 1'b1;
                    state_nxt = FETCH;
                end
            end
            HALT: begin
                if (!bus.run) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (zupd) zero_nxt = (acc_nxt == '0);
    end

    // kbd_ready and halted are registered copies of the next state so they
    // are high for exactly the cycles spent in WAIT_IN / HALT.
    always_ff @(posedge clk1 or negedge MainClear) begin
        if (!MainClear) begin
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            outv_q  <= 1'b0;
            kbdr_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_nxt;
            ir_q    <= ir_nxt;
            acc_q   <= acc_nxt;
            dout_q  <= dout_nxt;
            carry_q <= carry_nxt;
            zero_q  <= zero_nxt;
            outv_q  <= outv_nxt;
            kbdr_q  <= (state_nxt == WAIT_IN);
            halt_q  <= (state_nxt == HALT);
        end
    end

    always_ff @(posedge clk1 or negedge MainClear) begin
        if (!MainClear) begin
            for (int i = 0; i < 2**AW; i++) mem[AW'(i)] <= '0;
        end else if (bus.prog_we && (state == IDLE || state == HALT)) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign bus.kbd_ready = kbdr_q;
    assign bus.DataOut   = dout_q;
    assign bus.out_valid = outv_q;
    assign bus.acc       = acc_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.pc        = pc_q;
    assign bus.halted    = halt_q;

endmodule

// File: tb/tb_param_micro_proc.sv
// Bench for param_micro_proc: directed programs plus random forward-branching
// programs checked against an instruction-level interpreter.
module tb_param_micro_proc;
    logic clk1 = 1'b0;
    logic MainClear;
    int   nvec = 0, nmis = 0;

    logic [7:0]  img [8];
    logic [11:0] w1 [4];
    int kq[$];
    int kw[$];
    int cyc, outs, kdel, kcur, n;
    int m_acc, m_carry, m_zero, m_dout, m_pc, m_outs, m_cyc;

    always #5 clk1 = ~clk1;

    param_micro_proc_if #(.DW(4), .AW(3)) b0();
    param_micro_proc_if #(.DW(8), .AW(4)) b1();

    param_micro_proc #(.DW(4), .AW(3)) u0 (.clk1(clk1), .MainClear(MainClear), .bus(b0));
    param_micro_proc #(.DW(8), .AW(4)) u1 (.clk1(clk1), .MainClear(MainClear), .bus(b1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level interpreter; architectural state carries across runs.
    task automatic model();
        logic [2:0] p = 3'd0;
        int op, arg, steps = 0, ki = 0;
        bit h = 1'b0;
        m_outs = 0;
        m_cyc  = 0;
        while (!h && steps < 64) begin
            op  = int'(img[p][7:4]);
            arg = int'(img[p][3:0]);
            p   = p + 3'd1;
            m_cyc += 3;
            steps++;
            case (op)
                1: begin m_acc = m_acc + arg; m_carry = int'(m_acc > 15); m_acc = m_acc % 16; m_zero = int'(m_acc == 0); end
                2: begin m_carry = int'(m_acc < arg); m_acc = (m_acc - arg + 16) % 16; m_zero = int'(m_acc == 0); end
                3: begin m_dout = m_acc; m_outs++; end
                4: begin
                    if (ki < kq.size()) begin m_acc = kq[ki]; m_cyc += kw[ki]; end
                    ki++;
                    m_zero = int'(m_acc == 0);
                end
                5: begin m_acc = arg; m_zero = int'(m_acc == 0); end
                6: begin m_acc = m_acc & arg; m_zero = int'(m_acc == 0); end
                7: begin m_acc = m_acc | arg; m_zero = int'(m_acc == 0); end
                8: p = 3'(arg % 8);
                9: if (m_zero != 0) p = 3'(arg % 8);
                15: h = 1'b1;
                default: ;
            endcase
        end
        m_pc = int'(p);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_acc"},   32'(b0.acc),     32'(m_acc));
        chk({tag, "_carry"}, 32'(b0.carry),   32'(m_carry));
        chk({tag, "_zero"},  32'(b0.zero),    32'(m_zero));
        chk({tag, "_dout"},  32'(b0.DataOut), 32'(m_dout));
        chk({tag, "_pc"},    32'(b0.pc),      32'(m_pc));
        chk({tag, "_outs"},  32'(outs),       32'(m_outs));
        chk({tag, "_cycles"},32'(cyc),        32'(m_cyc));
    endtask

    task automatic apply_reset();
        @(negedge clk1);
        MainClear    = 1'b0;
        b0.run       = 1'b0;
        b0.prog_we   = 1'b0;
        b0.kbd_valid = 1'b0;
        m_acc = 0; m_carry = 0; m_zero = 0; m_dout = 0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk1);
        MainClear = 1'b1;
    endtask

    task automatic load_image();
        for (int i = 1; i < 8; i++) begin
            @(negedge clk1);
            b0.prog_we   = 1'b1;
            b0.prog_addr = 3'(i);
            b0.prog_data = img[3'(i)];
            @(posedge clk1);
        end
        @(negedge clk1);
        b0.prog_we = 1'b0;
    endtask

    // Word 0 is written in the same IDLE cycle that run is raised.
    task automatic start(input logic we, input logic [7:0] w0);
        @(negedge clk1);
        b0.prog_we   = we;
        b0.prog_addr = 3'd0;
        b0.prog_data = w0;
        b0.run       = 1'b1;
        @(posedge clk1);
        @(negedge clk1);
        b0.prog_we = 1'b0;
    endtask

    task automatic stop_prog();
        b0.run       = 1'b0;
        b0.kbd_valid = 1'b0;
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic run_prog(input int junk);
        start(1'b1, img[0]);
        cyc = 0; outs = 0;
        kq.delete(); kw.delete();
        kdel = $urandom_range(0, 3);
        kcur = kdel;
        while (b0.halted !== 1'b1 && cyc < 200) begin
            b0.prog_we   = (cyc < junk);
            b0.prog_addr = 3'd3;
            b0.prog_data = 8'h59;
            @(posedge clk1);
            cyc++;
            @(negedge clk1);
            b0.prog_we = 1'b0;
            if (b0.out_valid === 1'b1) outs++;
            b0.kbd_valid = 1'b0;
            if (b0.kbd_ready === 1'b1) begin
                if (kdel > 0) kdel--;
                else begin
                    b0.kbd_data  = 4'($urandom);
                    b0.kbd_valid = 1'b1;
                    kq.push_back(int'(b0.kbd_data));
                    kw.push_back(kcur + 1);
                    kdel = $urandom_range(0, 3);
                    kcur = kdel;
                end
            end
        end
        chk("halt_reached", 32'(b0.halted), 32'd1);
    endtask

    task automatic wait_kbd();
        n = 0;
        while (b0.kbd_ready !== 1'b1 && n < 20) begin
            @(posedge clk1);
            @(negedge clk1);
            n++;
        end
        chk("wait_in_reached", 32'(b0.kbd_ready), 32'd1);
    endtask

    task automatic set_img(input logic [7:0] a0, a1, a2, a3, a4, a5);
        img[0] = a0; img[1] = a1; img[2] = a2; img[3] = a3;
        img[4] = a4; img[5] = a5; img[6] = 8'h00; img[7] = 8'h00;
    endtask

    initial begin
        MainClear = 1'b0;
        b0.run = 1'b0; b0.prog_we = 1'b0; b0.prog_addr = '0; b0.prog_data = '0;
        b0.kbd_data = '0; b0.kbd_valid = 1'b0;
        b1.run = 1'b0; b1.prog_we = 1'b0; b1.prog_addr = '0; b1.prog_data = '0;
        b1.kbd_data = '0; b1.kbd_valid = 1'b0;
        m_acc = 0; m_carry = 0; m_zero = 0; m_dout = 0;
        repeat (2) @(negedge clk1);
        chk("rst_acc",    32'(b0.acc),       32'd0);
        chk("rst_carry",  32'(b0.carry),     32'd0);
        chk("rst_zero",   32'(b0.zero),      32'd0);
        chk("rst_dout",   32'(b0.DataOut),   32'd0);
        chk("rst_outv",   32'(b0.out_valid), 32'd0);
        chk("rst_kready", 32'(b0.kbd_ready), 32'd0);
        chk("rst_halted", 32'(b0.halted),    32'd0);
        chk("rst_pc",     32'(b0.pc),        32'd0);
        MainClear = 1'b1;

        // LDA 7, ADD 12, OUT, HLT
        set_img(8'h57, 8'h1C, 8'h30, 8'hF0, 8'h00, 8'h00);
        load_image();
        run_prog(0);
        model();
        check_model("arith");
        chk("arith_acc_k",   32'(b0.acc),     32'd3);
        chk("arith_carry_k", 32'(b0.carry),   32'd1);
        chk("arith_dout_k",  32'(b0.DataOut), 32'd3);
        chk("arith_cyc_k",   32'(cyc),        32'd12);
        chk("arith_outs_k",  32'(outs),       32'd1);
        stop_prog();

        // LDA 2, SUB 5, HLT then LDA 5, SUB 5, HLT
        set_img(8'h52, 8'h25, 8'hF0, 8'h00, 8'h00, 8'h00);
        load_image();
        run_prog(0);
        model();
        check_model("borrow");
        chk("borrow_acc_k",   32'(b0.acc),   32'd13);
        chk("borrow_carry_k", 32'(b0.carry), 32'd1);
        stop_prog();
        set_img(8'h55, 8'h25, 8'hF0, 8'h00, 8'h00, 8'h00);
        load_image();
        run_prog(0);
        model();
        check_model("sub_eq");
        chk("sub_eq_zero_k",  32'(b0.zero),  32'd1);
        chk("sub_eq_carry_k", 32'(b0.carry), 32'd0);
        stop_prog();

        // LDA 0, JZ 5, LDA 9, NOP, NOP, HLT
        set_img(8'h50, 8'h95, 8'h59, 8'h00, 8'h00, 8'hF0);
        load_image();
        run_prog(0);
        model();
        check_model("jz");
        chk("jz_acc_k", 32'(b0.acc), 32'd0);
        stop_prog();

        // NOP-only program: pc wraps 7 -> 0 -> 1 and never halts
        set_img(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        load_image();
        start(1'b1, 8'h00);
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk1);
            @(negedge clk1);
            chk("wrap_pc", 32'(b0.pc), 32'(((e - 1) / 3 + 1) % 8));
        end
        chk("wrap_no_halt", 32'(b0.halted), 32'd0);
        apply_reset();
        release_reset();

        // LDA 3, IN, OUT, HLT with a long keyboard stall
        set_img(8'h53, 8'h40, 8'h30, 8'hF0, 8'h00, 8'h00);
        load_image();
        start(1'b1, img[0]);
        wait_kbd();
        for (int i = 0; i < 10; i++) begin
            chk("stall_kready", 32'(b0.kbd_ready), 32'd1);
            chk("stall_acc",    32'(b0.acc),       32'd3);
            @(posedge clk1);
            @(negedge clk1);
        end
        b0.kbd_data  = 4'hA;
        b0.kbd_valid = 1'b1;
        @(posedge clk1);
        #1;
        chk("kbd_acc",    32'(b0.acc),       32'hA);
        chk("kbd_kready", 32'(b0.kbd_ready), 32'd0);
        chk("kbd_zero",   32'(b0.zero),      32'd0);
        @(negedge clk1);
        b0.kbd_valid = 1'b0;
        @(posedge clk1);
        #1;
        chk("kbd_fetch_pc", 32'(b0.pc), 32'd3);
        n = 0;
        while (b0.halted !== 1'b1 && n < 20) begin
            @(posedge clk1);
            @(negedge clk1);
            n++;
        end
        chk("kbd_halt", 32'(b0.halted),  32'd1);
        chk("kbd_dout", 32'(b0.DataOut), 32'hA);
        stop_prog();

        // Reset during EXEC of ADD: LDA 5, ADD 3, HLT
        set_img(8'h55, 8'h13, 8'hF0, 8'h00, 8'h00, 8'h00);
        load_image();
        start(1'b1, img[0]);
        repeat (5) @(posedge clk1);
        @(negedge clk1);
        chk("mid_pre_acc", 32'(b0.acc), 32'd5);
        MainClear = 1'b0;
        b0.run    = 1'b0;
        #1;
        chk("mid_acc",    32'(b0.acc),       32'd0);
        chk("mid_pc",     32'(b0.pc),        32'd0);
        chk("mid_carry",  32'(b0.carry),     32'd0);
        chk("mid_zero",   32'(b0.zero),      32'd0);
        chk("mid_dout",   32'(b0.DataOut),   32'd0);
        chk("mid_outv",   32'(b0.out_valid), 32'd0);
        chk("mid_kready", 32'(b0.kbd_ready), 32'd0);
        chk("mid_halted", 32'(b0.halted),    32'd0);
        release_reset();
        m_acc = 0; m_carry = 0; m_zero = 0; m_dout = 0;
        start(1'b0, 8'h00);
        repeat (12) @(posedge clk1);
        @(negedge clk1);
        chk("cleared_mem_acc",  32'(b0.acc),    32'd0);
        chk("cleared_mem_halt", 32'(b0.halted), 32'd0);
        chk("cleared_mem_pc",   32'(b0.pc),     32'd4);
        apply_reset();
        release_reset();

        // Reset while stalled in WAIT_IN
        set_img(8'h40, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00);
        load_image();
        start(1'b1, img[0]);
        wait_kbd();
        apply_reset();
        chk("wait_rst_kready", 32'(b0.kbd_ready), 32'd0);
        chk("wait_rst_pc",     32'(b0.pc),        32'd0);
        chk("wait_rst_acc",    32'(b0.acc),       32'd0);
        release_reset();

        // Writes while running must not land: LDA 1, NOP, NOP, HLT
        set_img(8'h51, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h00);
        load_image();
        run_prog(6);
        model();
        check_model("we_running");
        chk("we_running_acc_k", 32'(b0.acc), 32'd1);
        stop_prog();

        // Random forward-branching programs ending in HLT
        for (int t = 0; t < 12; t++) begin
            int op, arg, tgt;
            for (int a = 0; a < 7; a++) begin
                op  = $urandom_range(0, 15);
                arg = $urandom_range(0, 15);
                if (op == 8 || op == 9) begin
                    tgt = a + 1 + $urandom_range(0, 6 - a);
                    arg = 8 * $urandom_range(0, 1) + tgt;
                end
                img[3'(a)] = {4'(op), 4'(arg)};
            end
            img[7] = 8'hF0;
            load_image();
            run_prog(0);
            model();
            check_model("rand");
            stop_prog();
        end

        // Wide instance: LDA 0x02, ADD 0xFF, OUT, HLT
        w1[0] = 12'h502; w1[1] = 12'h1FF; w1[2] = 12'h300; w1[3] = 12'hF00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk1);
            b1.prog_we   = 1'b1;
            b1.prog_addr = 4'(i);
            b1.prog_data = w1[2'(i)];
            @(posedge clk1);
        end
        @(negedge clk1);
        b1.prog_we = 1'b0;
        b1.run     = 1'b1;
        @(posedge clk1);
        @(negedge clk1);
        n = 0;
        while (b1.halted !== 1'b1 && n < 40) begin
            @(posedge clk1);
            n++;
            @(negedge clk1);
        end
        chk("wide_acc",   32'(b1.acc),     32'h01);
        chk("wide_carry", 32'(b1.carry),   32'd1);
        chk("wide_zero",  32'(b1.zero),    32'd0);
        chk("wide_dout",  32'(b1.DataOut), 32'h01);
        chk("wide_cyc",   32'(n),          32'd12);
        b1.run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
